hex_reply_receiver: RTL and testbench

Host-side reader for the calculator's UART reply stream. The calculator transmits each accumulator value as two uppercase hex ASCII characters followed by a space (0x20). This block deserialises 8N1 UART frames, parses the "HH " token stream, and presents each reconstructed 8-bit value with a one-cycle strobe. It is used as the test harness and loopback partner on a second board or FPGA, with the calculator's serial output wired to serial_in.

---
 rtl/hex_reply_receiver.sv | 228 ++++++++++++++++++++++
 tb/tb_hex_reply_receiver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_reply_receiver.sv
// UART (8N1) receiver plus "HH " token parser for the calculator's reply stream.
// Each reconstructed byte value is presented on value_out with a one-cycle strobe.
module hex_reply_receiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_busy,
    output logic [7:0] value_out,
    output logic       value_valid,
    output logic [7:0] value_count,
    output logic       frame_err,
    output logic       parse_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] P_EXP_HI  = 2'd0;
    localparam logic [1:0] P_EXP_LO  = 2'd1;
    localparam logic [1:0] P_EXP_SEP = 2'd2;

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          brk_q, brk_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;

    logic [1:0]    pstate_q, pstate_d;
    logic [3:0]    hi_q, hi_d, lo_q, lo_d;
    logic [7:0]    value_q, value_d;
    logic          value_valid_q, value_valid_d;
    logic [7:0]    count_q, count_d;
    logic          parse_err_q, parse_err_d;

    logic          hex_ok;
    logic [3:0]    hex_val;
    logic          line;

    assign line = sync2_q;

    // Bit-level FSM; brk_q holds us in STOP after a low stop bit until the line recovers.
    always_comb begin
        sync1_d     = serial_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        brk_d       = brk_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!line) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == HALF_M1) begin
                    if (!line) begin
                        state_d   = S_DATA;
                        timer_d   = '0;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    shift_d = {line, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (brk_q) begin
                    if (line) begin
                        brk_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (timer_q == FULL_M1) begin
                    if (line) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_d       = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hex_ok  = 1'b1;
        hex_val = 4'd0;
        if (rx_byte_q >= 8'h30 && rx_byte_q <= 8'h39) begin
            hex_val = rx_byte_q[3:0];
        end else if ((rx_byte_q >= 8'h41 && rx_byte_q <= 8'h46) ||
                     (rx_byte_q >= 8'h61 && rx_byte_q <= 8'h66)) begin
            hex_val = rx_byte_q[3:0] + 4'd9;
        end else begin
            hex_ok = 1'b0;
        end
    end

    // Token parser, stepped once per accepted byte.
    always_comb begin
        pstate_d      = pstate_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        count_d       = count_q;
        parse_err_d   = 1'b0;
        if (rx_valid_q) begin
            case (pstate_q)
                P_EXP_HI: begin
                    if (hex_ok) begin
                        hi_d     = hex_val;
                        pstate_d = P_EXP_LO;
                    end else if (!(rx_byte_q == 8'h20 || rx_byte_q == 8'h0D || rx_byte_q == 8'h0A)) begin
                        parse_err_d = 1'b1;
                    end
                end
                P_EXP_LO: begin
                    if (hex_ok) begin
                        lo_d     = hex_val;
                        pstate_d = P_EXP_SEP;
                    end else begin
                        parse_err_d = 1'b1;
                        pstate_d    = P_EXP_HI;
                    end
                end
                P_EXP_SEP: begin
                    if (rx_byte_q == 8'h20) begin
                        value_d       = {hi_q, lo_q};
                        value_valid_d = 1'b1;
                        count_d       = count_q + 8'd1;
                    end else begin
                        parse_err_d = 1'b1;
                    end
                    pstate_d = P_EXP_HI;
                end
                default: pstate_d = P_EXP_HI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= S_IDLE;
            timer_q       <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            brk_q         <= 1'b0;
            rx_byte_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            pstate_q      <= P_EXP_HI;
            hi_q          <= 4'd0;
            lo_q          <= 4'd0;
            value_q       <= 8'd0;
            value_valid_q <= 1'b0;
            count_q       <= 8'd0;
            parse_err_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            brk_q         <= brk_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            pstate_q      <= pstate_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            count_q       <= count_d;
            parse_err_q   <= parse_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_valid_q;
    assign rx_busy       = (state_q != S_IDLE);
    assign value_out     = value_q;
    assign value_valid   = value_valid_q;
    assign value_count   = count_q;
    assign frame_err     = frame_err_q;
    assign parse_err     = parse_err_q;

endmodule

// File: tb/tb_hex_reply_receiver.sv
// Randomised bench for hex_reply_receiver: UART frames are driven bit by bit and the
// observed strobes are compared against a token-buffer model of the reply grammar.
module tb_hex_reply_receiver;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_busy;
    logic [7:0] value_out;
    logic       value_valid;
    logic [7:0] value_count;
    logic       frame_err;
    logic       parse_err;

    hex_reply_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_busy       (rx_busy),
        .value_out     (value_out),
        .value_valid   (value_valid),
        .value_count   (value_count),
        .frame_err     (frame_err),
        .parse_err     (parse_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] obs_rx[$];
    logic [7:0] obs_val[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_val[$];
    int obs_perr = 0, obs_ferr = 0, exp_perr = 0, exp_ferr = 0;
    int strobe_long = 0, strobe_both = 0;
    logic prev_rv = 0, prev_vv = 0, prev_fe = 0, prev_pe = 0;

    logic [7:0] tok[$];
    int         model_count = 0;
    logic [7:0] model_value = 8'd0;
    logic [7:0] model_rx    = 8'd0;

    always @(negedge clk) begin
        if (rx_byte_valid) obs_rx.push_back(rx_byte);
        if (value_valid) obs_val.push_back(value_out);
        if (parse_err) obs_perr++;
        if (frame_err) obs_ferr++;
        if ((rx_byte_valid && prev_rv) || (value_valid && prev_vv) ||
            (frame_err && prev_fe) || (parse_err && prev_pe)) strobe_long++;
        if (value_valid && parse_err) strobe_both++;
        prev_rv = rx_byte_valid;
        prev_vv = value_valid;
        prev_fe = frame_err;
        prev_pe = parse_err;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit isHex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hexVal(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return int'(c) - 87;
    endfunction

    function automatic logic [7:0] hexChar(input logic [3:0] n, input bit lower);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        return (lower ? 8'h61 : 8'h41) + {4'd0, n} - 8'd10;
    endfunction

    // Reference grammar: collect two hex chars, then a space releases the value.
    task automatic modelByte(input logic [7:0] c);
        exp_rx.push_back(c);
        model_rx = c;
        if (tok.size() == 0) begin
            if (isHex(c)) tok.push_back(c);
            else if (!(c == 8'h20 || c == 8'h0D || c == 8'h0A)) exp_perr++;
        end else if (tok.size() == 1) begin
            if (isHex(c)) tok.push_back(c);
            else begin
                exp_perr++;
                tok.delete();
            end
        end else begin
            if (c == 8'h20) begin
                model_value = 8'((hexVal(tok[0]) << 4) | hexVal(tok[1]));
                exp_val.push_back(model_value);
                model_count = (model_count + 1) % 256;
            end else begin
                exp_perr++;
            end
            tok.delete();
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] c, input bit good_stop, input int gap);
        serial_in = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = c[i];
            waitCycles(CPB);
        end
        serial_in = good_stop;
        waitCycles(CPB);
        if (!good_stop) begin
            waitCycles(2 * CPB);
            exp_ferr++;
        end else begin
            modelByte(c);
        end
        serial_in = 1'b1;
        if (gap > 0) waitCycles(gap);
    endtask

    task automatic sendString(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1, gap);
    endtask

    task automatic sendToken(input logic [7:0] v, input bit lower, input int gap);
        applyStimulus(hexChar(v[7:4], lower), 1'b1, gap);
        applyStimulus(hexChar(v[3:0], lower), 1'b1, gap);
        applyStimulus(8'h20, 1'b1, gap);
    endtask

    task automatic clearRecords();
        obs_rx.delete();
        obs_val.delete();
        exp_rx.delete();
        exp_val.delete();
        obs_perr = 0;
        obs_ferr = 0;
        exp_perr = 0;
        exp_ferr = 0;
    endtask

    task automatic verifyPhase(input string tag);
        waitCycles(3 * CPB);
        checkOutput({tag, "_nrx"}, obs_rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size(); i++)
            if (i < obs_rx.size()) checkOutput({tag, "_rxbyte"}, obs_rx[i], exp_rx[i]);
        checkOutput({tag, "_nval"}, obs_val.size(), exp_val.size());
        for (int i = 0; i < exp_val.size(); i++)
            if (i < obs_val.size()) checkOutput({tag, "_value"}, obs_val[i], exp_val[i]);
        checkOutput({tag, "_parse_err"}, obs_perr, exp_perr);
        checkOutput({tag, "_frame_err"}, obs_ferr, exp_ferr);
        checkOutput({tag, "_count"}, value_count, model_count);
        checkOutput({tag, "_value_out"}, value_out, model_value);
        checkOutput({tag, "_rx_byte"}, rx_byte, model_rx);
        checkOutput({tag, "_busy"}, rx_busy, 0);
        clearRecords();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_byte"}, rx_byte, 0);
        checkOutput({tag, "_rx_valid"}, rx_byte_valid, 0);
        checkOutput({tag, "_busy"}, rx_busy, 0);
        checkOutput({tag, "_value_out"}, value_out, 0);
        checkOutput({tag, "_value_valid"}, value_valid, 0);
        checkOutput({tag, "_count"}, value_count, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
        checkOutput({tag, "_parse_err"}, parse_err, 0);
    endtask

    task automatic resetModel();
        tok.delete();
        model_count = 0;
        model_value = 8'd0;
        model_rx    = 8'd0;
        clearRecords();
    endtask

    initial begin
        bit busy_seen;
        reset_n   = 1'b0;
        serial_in = 1'b1;
        waitCycles(3);
        checkAllZero("reset");
        reset_n = 1'b1;
        waitCycles(2);

        sendString("3A ", CPB);
        verifyPhase("t1");

        sendString("0f 10 ", 0);
        verifyPhase("t2");

        sendString("4G ", 0);
        verifyPhase("t3a");
        sendString("55 ", 0);
        verifyPhase("t3b");

        applyStimulus(8'h41, 1'b0, CPB);
        verifyPhase("t4a");
        sendString("12 ", 0);
        verifyPhase("t4b");

        // Short low pulse on the idle line must be rejected as a false start.
        busy_seen = 1'b0;
        serial_in = 1'b0;
        waitCycles(2);
        serial_in = 1'b1;
        for (int i = 0; i < CPB / 2 + 3; i++) begin
            waitCycles(1);
            if (rx_busy) busy_seen = 1'b1;
        end
        checkOutput("glitch_busy_seen", busy_seen, 1);
        checkOutput("glitch_busy_end", rx_busy, 0);
        verifyPhase("t5");

        applyStimulus("7", 1'b1, 0);
        serial_in = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 3; i++) begin
            serial_in = ((8'h45 >> i) & 8'h01) != 0;
            waitCycles(CPB);
        end
        reset_n   = 1'b0;
        serial_in = 1'b1;
        #1;
        checkAllZero("midreset");
        waitCycles(2);
        reset_n = 1'b1;
        resetModel();
        waitCycles(2);
        sendString("7E ", CPB);
        verifyPhase("t6");

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0)
                sendToken(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, CPB));
            else
                applyStimulus(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, CPB));
        end
        verifyPhase("t7");

        reset_n = 1'b0;
        waitCycles(2);
        checkAllZero("wrapreset");
        reset_n = 1'b1;
        resetModel();
        waitCycles(2);
        for (int n = 0; n < 256; n++) sendToken(8'(n), 1'b0, 0);
        verifyPhase("t8");
        checkOutput("wrap_count", value_count, 0);

        checkOutput("strobe_width", strobe_long, 0);
        checkOutput("strobe_exclusive", strobe_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
